pc_fetch: RTL
=============

Name: pc_fetch

Overview:
- Fetch-stage PC unit for the P7 pipelined MIPS core.
- Owns the F-stage PC register and computes the next PC from the 3-bit PC_sel code produced by the D-stage branch comparator, plus exception entry and eret return requests from CP0.
- Flags fetch address errors (AdEL) and delay-slot status for the instruction in F.
- Drives the instruction-memory address and the F/D pipeline register kill.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of F and D.
- req  in  1  CP0 exception/interrupt request; 1-cycle pulse.
- epc  in  32  CP0 EPC, used for eret.
- pc_sel  in  3  redirect code from D: 000 seq, 001 branch taken, 010 j/jal, 011 jr/jalr, 100 eret, 101..111 treated as 000.
- pc_d  in  32  PC of the instruction in D.
- imm16  in  16  branch offset of the D instruction.
- instr_index  in  26  jump index of the D instruction.
- rs_val  in  32  forwarded rs value for jr/jalr.
- is_jump_d  in  1  D instruction is any branch/jump (taken or not).
- pc_f  out  32  current fetch PC; IM address.
- adel_f  out  1  fetch address error for pc_f.
- bd_f  out  1  instruction in F is a delay slot.
- kill_f  out  1  F/D register loads a nop instead of the fetched word.

Behaviour:
- Next-PC sources; all arithmetic is 32-bit with wrap, no saturation:
  - seq = pc_f+4.
  - br = pc_d+4+(sign_ext(imm16)<<2).
  - jmp = {pc_d[31:28],instr_index,2'b00}.
  - jr = rs_val.
  - ret = epc.
- Priority each cycle: reset > req > stall > pc_sel.
  - reset: pc_f=RESET_PC asynchronously; FSM=RUN; all 1-bit outputs 0.
  - req=1: pc_f<=HANDLER_PC at the next edge regardless of stall or pc_sel; FSM->EXC.
  - stall=1 and req=0: pc_f holds; FSM->HOLD.
  - Otherwise: pc_f<=selected source; FSM->RUN.
- FSM states:
  - RUN: normal operation.
  - HOLD: entered on stall. Returns to RUN on the first non-stalled edge. A redirect from a D-stage instruction that was frozen is applied exactly once, on that edge.
  - EXC: single cycle after handler entry. bd_f forced 0 and kill_f forced 0. An incoming pc_sel is still honoured. Exits to RUN, or to HOLD if stall=1.
- adel_f is combinational on pc_f: pc_f[1:0]!=0, or pc_f<IM_LO, or pc_f>IM_HI. The PC still advances normally after AdEL; CP0 raises req.
- A jr to a misaligned target is loaded as-is; adel_f flags it the following cycle.
- bd_f = is_jump_d & ~stall & (state!=EXC).
- kill_f = (pc_sel==100) & ~stall & ~req. eret has no delay slot.
- Latency: redirect decided in D takes effect on pc_f one edge later. The delay-slot instruction is fetched in the same cycle as the redirect.
- Reset asserted mid-stall or mid-redirect: all pending state is discarded.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- With the macro defined, add outputs redirect_cnt[31:0] and stall_cnt[31:0].
  - redirect_cnt increments on every non-stalled edge with pc_sel in 001..100, or with req=1.
  - stall_cnt increments on every edge with stall=1 and req=0.
  - Both counters reset to 0 and wrap at 2^32.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - the PC_SEL_SEQ/BR/J/JR/ERET 3-bit constants (shared with the branch comparator);
  - the FSM state typedef;
  - the RESET_PC, HANDLER_PC, IM_LO and IM_HI defaults.
- One natural sub-module, npc_calc: purely combinational next-PC mux and target adders.
- pc_fetch keeps the register, FSM, AdEL check and counters.

Test Plan:
- Reset release, no redirects -> pc_f steps 0x3000, 0x3004, 0x3008; adel_f=0, bd_f=0.
- pc_d=0x3010, imm16=0xFFFC, pc_sel=001, is_jump_d=1 -> bd_f=1 that cycle; next pc_f=0x3004.
- stall=1 for 3 cycles with pc_sel=010, instr_index=0x0000C40 -> pc_f holds. After stall drops, next pc_f=0x00003100; redirect_cnt +1 only.
- req pulse coincident with stall=1 and pc_sel=011 -> next pc_f=0x4180. Following cycle bd_f=0 even with is_jump_d=1.
- pc_sel=100, epc=0x3020 -> kill_f=1 that cycle; next pc_f=0x3020.
- pc_sel=011, rs_val=0x3002 -> pc_f=0x3002, adel_f=1. rs_val=0x7000 -> adel_f=1. Reset asserted mid-sequence -> pc_f=0x3000 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the P7 MIPS fetch path: redirect codes, fetch FSM states
// and the default memory-map constants used by the PC unit.
package mips_pkg;

    localparam logic [2:0] PC_SEL_SEQ  = 3'b000;
    localparam logic [2:0] PC_SEL_BR   = 3'b001;
    localparam logic [2:0] PC_SEL_J    = 3'b010;
    localparam logic [2:0] PC_SEL_JR   = 3'b011;
    localparam logic [2:0] PC_SEL_ERET = 3'b100;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_EXC  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;

    // Codes 101..111 are unused by the comparator and fall back to sequential fetch.
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == PC_SEL_BR) || (sel == PC_SEL_J) ||
               (sel == PC_SEL_JR) || (sel == PC_SEL_ERET);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump, register jump and eret
// targets, all computed with plain 32-bit wrapping arithmetic.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] epc_i,
    input  logic [2:0]  pc_sel_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_tgt;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] br_off;

    assign br_off  = {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign seq_tgt = pc_f_i + 32'd4;
    assign br_tgt  = pc_d_i + 32'd4 + br_off;
    assign jmp_tgt = {pc_d_i[31:28], instr_index_i, 2'b00};

    always_comb begin
        npc_o = seq_tgt;
        case (pc_sel_i)
            PC_SEL_BR:   npc_o = br_tgt;
            PC_SEL_J:    npc_o = jmp_tgt;
            PC_SEL_JR:   npc_o = rs_val_i;
            PC_SEL_ERET: npc_o = epc_i;
            default:     npc_o = seq_tgt;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch-stage PC unit: PC register, RUN/HOLD/EXC FSM, AdEL check and F/D kill.
// Define PC_FETCH_PERF_EN to add the redirect_cnt/stall_cnt performance counters.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [31:0] epc,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic        is_jump_d,
    output logic [31:0] pc_f,
    output logic        adel_f,
    output logic        bd_f,
    output logic        kill_f
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  npc;

    npc_calc u_npc_calc (
        .pc_f_i        (fpc_q),
        .pc_d_i        (pc_d),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .rs_val_i      (rs_val),
        .epc_i         (epc),
        .pc_sel_i      (pc_sel),
        .npc_o         (npc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            fpc_q   <= fpc_d;
            state_q <= state_d;
        end
    end

    // D stays frozen during a stall, so its redirect is simply taken on the first free edge.
    always_comb begin
        fpc_d   = fpc_q;
        state_d = state_q;
        if (req) begin
            fpc_d   = HANDLER_PC;
            state_d = ST_EXC;
        end else if (stall) begin
            state_d = ST_HOLD;
        end else begin
            fpc_d   = npc;
            state_d = ST_RUN;
        end
    end

    assign pc_f   = fpc_q;
    assign adel_f = (fpc_q[1:0] != 2'b00) || (fpc_q < IM_LO) || (fpc_q > IM_HI);
    assign bd_f   = ~reset & is_jump_d & ~stall & (state_q != ST_EXC);
    assign kill_f = ~reset & (pc_sel == PC_SEL_ERET) & ~stall & ~req & (state_q != ST_EXC);

`ifdef PC_FETCH_PERF_EN
    logic [31:0] redirect_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            if (req || (!stall && is_redirect(pc_sel))) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (stall && !req) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule
